// File: rtl/xbus_pkg.sv
// rtl/xbus_pkg.sv - shared types and constants for the darkram X-port read master
package xbus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } xbus_state_e;

   localparam logic [3:0] XBE_ALL     = 4'hf;
   localparam int         WORD_STRIDE = 4;

endpackage

// File: rtl/xbus_read_master_if.sv
// rtl/xbus_read_master_if.sv - darkram X data port signal bundle
interface xbus_read_master_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  XDREQ;
   logic                  XRD;
   logic                  XWR;
   logic [3:0]            XBE;
   logic [ADDR_WIDTH-1:0] XADDR;
   logic [31:0]           XATAI;
   logic [31:0]           XATAO;
   logic                  XDACK;

   modport master (
      output XDREQ, XRD, XWR, XBE, XADDR, XATAI,
      input  XATAO, XDACK
   );

   modport slave (
      input  XDREQ, XRD, XWR, XBE, XADDR, XATAI,
      output XATAO, XDACK
   );
endinterface

// File: rtl/xbus_read_master.sv
// rtl/xbus_read_master.sv - burst reader for the darkram X port with running checksum
module xbus_read_master
   import xbus_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [15:0]           word_count,
   input  logic                  advance,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           rd_data,
   output logic                  rd_valid,
   output logic [31:0]           checksum,
   xbus_read_master_if.master    xbus
);

   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   xbus_state_e           state_q, state_d;
   logic [15:0]           remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           rd_data_q, rd_data_d;
   logic [31:0]           checksum_q, checksum_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  xdreq_q, xdreq_d;
   logic                  base_lsb_unused;

   // Byte lanes of the base address are discarded; darkram is word addressed.
   assign base_lsb_unused = ^base_addr[1:0];

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      rd_data_d   = rd_data_q;
      checksum_d  = checksum_q;
      tmo_d       = tmo_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      rd_valid_d  = 1'b0;
      xdreq_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               checksum_d = '0;
               error_d    = 1'b0;
               if (word_count != 16'd0) begin
                  addr_d      = {base_addr[ADDR_WIDTH-1:2], 2'b00};
                  remaining_d = word_count;
                  busy_d      = 1'b1;
                  tmo_d       = '0;
                  xdreq_d     = 1'b1;
                  state_d     = REQ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         REQ: begin
            if (xbus.XDACK) begin
               rd_data_d   = xbus.XATAO;
               rd_valid_d  = 1'b1;
               checksum_d  = checksum_q + xbus.XATAO;
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(WORD_STRIDE);
                  state_d = HOLD;
               end
            end else if (tmo_q == TMO_LAST) begin
               // Abandon the burst; the partial checksum is kept for inspection.
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               tmo_d   = tmo_q + TW'(1);
               xdreq_d = 1'b1;
            end
         end

         HOLD: begin
            if (advance) begin
               tmo_d   = '0;
               xdreq_d = 1'b1;
               state_d = REQ;
            end
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         addr_q      <= '0;
         rd_data_q   <= '0;
         checksum_q  <= '0;
         tmo_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         rd_valid_q  <= 1'b0;
         xdreq_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         rd_data_q   <= rd_data_d;
         checksum_q  <= checksum_d;
         tmo_q       <= tmo_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         rd_valid_q  <= rd_valid_d;
         xdreq_q     <= xdreq_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign checksum = checksum_q;

   assign xbus.XDREQ = xdreq_q;
   assign xbus.XRD   = xdreq_q;
   assign xbus.XWR   = 1'b0;
   assign xbus.XBE   = XBE_ALL;
   assign xbus.XADDR = addr_q;
   assign xbus.XATAI = '0;

endmodule

// File: tb/tb_xbus_read_master.sv
// tb/tb_xbus_read_master.sv - self-checking bench for xbus_read_master
module tb_xbus_read_master;
   import xbus_pkg::*;

   localparam int AW  = 32;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [15:0]   word_count;
   logic          advance;
   logic          busy, done, error, rd_valid;
   logic [31:0]   rd_data, checksum;

   xbus_read_master_if #(.ADDR_WIDTH(AW)) xbus ();

   xbus_read_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .advance    (advance),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .checksum   (checksum),
      .xbus       (xbus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      int          count;
      int          lat;
      logic [31:0] words [4];
      logic [31:0] cks;
      logic [31:0] last;
      bit          restart;
   } vec_t;

   vec_t        vecs [4];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_addr_q [$];
   logic [31:0] resp_q [$];
   logic [31:0] exp_data_q [$];
   logic [31:0] sum_model = '0;
   int          done_cnt = 0, valid_cnt = 0, req_cycles = 0;
   int          ack_lat = 1;
   bit          never_ack = 1'b0;
   int          wait_cnt = 0;
   bit          acked = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=unexpected required=none", name);
   endtask

   // darkram model: acks ack_lat cycles after XDREQ rises, data from resp_q
   always @(posedge clk) begin
      #1;
      if (reset || !xbus.XDREQ) begin
         xbus.XDACK = 1'b0;
         wait_cnt   = 0;
         acked      = 1'b0;
      end else if (acked) begin
         xbus.XDACK = 1'b0;
      end else if (!never_ack && wait_cnt >= ack_lat) begin
         if (exp_addr_q.size() == 0) fail_now("unexpected_request");
         else check("xaddr", xbus.XADDR, exp_addr_q.pop_front());
         xbus.XATAO = (resp_q.size() != 0) ? resp_q.pop_front() : 32'h0;
         xbus.XDACK = 1'b1;
         acked      = 1'b1;
      end else begin
         wait_cnt++;
         xbus.XDACK = 1'b0;
      end
   end

   // scoreboard: words expected in order, checksum tracked independently
   always @(negedge clk) begin : mon
      logic [31:0] w;
      if (!reset) begin
         if (xbus.XDREQ) req_cycles++;
         if (done) done_cnt++;
         if (rd_valid) begin
            valid_cnt++;
            if (exp_data_q.size() == 0) fail_now("unexpected_rd_valid");
            else begin
               w = exp_data_q.pop_front();
               sum_model = sum_model + w;
               check("rd_data", rd_data, w);
               check("checksum_running", checksum, sum_model);
            end
         end
      end
   end

   task automatic set_vec(input int idx, input logic [31:0] base, input int count, input int lat,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input logic [31:0] cks, input logic [31:0] last,
                          input bit restart);
      vecs[idx].base     = base;
      vecs[idx].count    = count;
      vecs[idx].lat      = lat;
      vecs[idx].words[0] = w0;
      vecs[idx].words[1] = w1;
      vecs[idx].words[2] = w2;
      vecs[idx].words[3] = w3;
      vecs[idx].cks      = cks;
      vecs[idx].last     = last;
      vecs[idx].restart  = restart;
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [15:0] cnt, input bit clear_model);
      @(posedge clk);
      #1;
      base_addr  = base;
      word_count = cnt;
      start      = 1'b1;
      if (clear_model) sum_model = '0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) fail_now(name);
      repeat (2) @(negedge clk);
   endtask

   task automatic load_burst(input logic [31:0] base, input int count, input vec_t v);
      logic [31:0] a0;
      a0 = {base[31:2], 2'b00};
      for (int i = 0; i < count; i++) begin
         exp_addr_q.push_back(a0 + 32'(4 * i));
         resp_q.push_back(v.words[i]);
         exp_data_q.push_back(v.words[i]);
      end
   endtask

   task automatic run_vec(input vec_t v);
      done_cnt  = 0;
      valid_cnt = 0;
      ack_lat   = v.lat;
      never_ack = 1'b0;
      advance   = 1'b1;
      load_burst(v.base, v.count, v);
      pulse_start(v.base, 16'(v.count), 1'b1);
      check("busy_after_start", {31'b0, busy}, 32'd1);
      if (v.restart) pulse_start(32'h500, 16'd7, 1'b0);
      wait_done("done_timeout", 200);
      check("done_count", 32'(done_cnt), 32'd1);
      check("valid_count", 32'(valid_cnt), 32'(v.count));
      check("checksum_final", checksum, v.cks);
      check("last_xaddr", xbus.XADDR, v.last);
      check("busy_end", {31'b0, busy}, 32'd0);
      check("error_end", {31'b0, error}, 32'd0);
      check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
   endtask

   initial begin : main
      int n;
      int hi;
      vec_t pv;

      reset = 1'b1;
      start = 1'b0;
      base_addr = '0;
      word_count = '0;
      advance = 1'b1;
      xbus.XDACK = 1'b0;
      xbus.XATAO = '0;

      set_vec(0, 32'h0000_0010, 1, 1, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 32'h0000_0010, 1'b0);
      set_vec(1, 32'h0000_0000, 4, 1, 32'h1, 32'h2, 32'h3, 32'hFFFFFFFF, 32'h0000_0005, 32'h0000_000C, 1'b1);
      set_vec(2, 32'hFFFF_FFFC, 2, 0, 32'h100, 32'h200, 0, 0, 32'h0000_0300, 32'h0000_0000, 1'b0);
      set_vec(3, 32'h0000_0013, 3, 2, 32'h80000000, 32'h80000000, 32'h11111111, 0,
              32'h1111_1111, 32'h0000_0018, 1'b0);

      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_error", {31'b0, error}, 32'd0);
      check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      check("rst_xdreq", {31'b0, xbus.XDREQ}, 32'd0);
      check("rst_xrd", {31'b0, xbus.XRD}, 32'd0);
      check("rst_xaddr", xbus.XADDR, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_checksum", checksum, 32'd0);
      check("xwr_const", {31'b0, xbus.XWR}, 32'd0);
      check("xbe_const", {28'b0, xbus.XBE}, 32'h0000_000f);
      check("xatai_const", xbus.XATAI, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // pacing: advance low holds the master between words
      advance = 1'b0;
      done_cnt = 0;
      ack_lat = 1;
      pv = vecs[0];
      pv.words[0] = 32'hA5A5A5A5;
      pv.words[1] = 32'h5A5A5A5A;
      load_burst(32'h0, 2, pv);
      pulse_start(32'h0, 16'd2, 1'b1);
      n = 0;
      while (!rd_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rd_valid) fail_now("pace_first_word");
      hi = 0;
      repeat (10) begin
         @(negedge clk);
         if (xbus.XDREQ) hi++;
      end
      check("pace_hold_low", 32'(hi), 32'd0);
      @(posedge clk);
      #1;
      advance = 1'b1;
      check("pace_still_low", {31'b0, xbus.XDREQ}, 32'd0);
      @(posedge clk);
      #1;
      check("pace_req_rise", {31'b0, xbus.XDREQ}, 32'd1);
      check("pace_xrd", {31'b0, xbus.XRD}, 32'd1);
      check("pace_xaddr", xbus.XADDR, 32'h4);
      wait_done("pace_done", 100);
      check("pace_checksum", checksum, 32'hFFFFFFFF);
      check("pace_done_count", 32'(done_cnt), 32'd1);

      // timeout: no ack ever arrives
      never_ack = 1'b1;
      done_cnt = 0;
      req_cycles = 0;
      pulse_start(32'h40, 16'd3, 1'b1);
      n = 1;
      @(negedge clk);
      while (!error && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("tmo_error", {31'b0, error}, 32'd1);
      check("tmo_latency", 32'(n), 32'(TMO + 1));
      check("tmo_xdreq", {31'b0, xbus.XDREQ}, 32'd0);
      check("tmo_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("tmo_req_cycles", 32'(req_cycles), 32'(TMO));
      check("tmo_no_done", 32'(done_cnt), 32'd0);
      never_ack = 1'b0;

      // zero-length start clears error and pulses done without bus traffic
      req_cycles = 0;
      pulse_start(32'h80, 16'd0, 1'b1);
      check("zero_done", {31'b0, done}, 32'd1);
      check("zero_error_clr", {31'b0, error}, 32'd0);
      check("zero_busy", {31'b0, busy}, 32'd0);
      check("zero_checksum", checksum, 32'd0);
      repeat (3) @(negedge clk);
      check("zero_no_req", 32'(req_cycles), 32'd0);
      check("zero_done_count", 32'(done_cnt), 32'd1);

      // reset while a request is outstanding
      ack_lat = 3;
      pv.words[0] = 32'h11;
      pv.words[1] = 32'h22;
      pv.words[2] = 32'h33;
      pv.words[3] = 32'h44;
      load_burst(32'h100, 4, pv);
      pulse_start(32'h100, 16'd4, 1'b1);
      n = 0;
      while (!rd_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!xbus.XDREQ && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("mid_xdreq_before", {31'b0, xbus.XDREQ}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_busy", {31'b0, busy}, 32'd0);
      check("mid_xdreq", {31'b0, xbus.XDREQ}, 32'd0);
      check("mid_checksum", checksum, 32'd0);
      check("mid_rd_data", rd_data, 32'd0);
      exp_addr_q.delete();
      resp_q.delete();
      exp_data_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/xbus_read_master.md
# xbus_read_master

Bus initiator for the X data port of the `darkram` block RAM. It issues a burst of single-word reads over XDREQ/XRD/XADDR, waits for XDACK on each, and streams the captured words out with a running checksum. Each word can be paced by an external `advance` strobe. It replaces the tied-off X-port request inputs in board-level test tops, for example LED or UART memory dumps.

## Interface
- `ADDR_WIDTH`, 32, width of XADDR and base_addr (byte address).
- `TIMEOUT`, 255, maximum cycles XDREQ may stay high without XDACK; range 1..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a burst; honoured only when idle.
- `base_addr`  in  ADDR_WIDTH  first byte address; bits [1:0] ignored (treated as 0); sampled on accepted start.
- `word_count`  in  16  number of words to read; sampled on accepted start.
- `advance`  in  1  level; while low, the master holds between words; tie high for back-to-back operation.
- `busy`  out  1  high from accepted start until the burst ends.
- `done`  out  1  one-cycle pulse when the burst ends normally.
- `error`  out  1  sticky timeout flag; cleared by the next accepted start or by reset.
- `rd_data`  out  32  last captured word.
- `rd_valid`  out  1  one-cycle pulse, rd_data updated.
- `checksum`  out  32  sum mod 2^32 of all words captured since the last accepted start.
- `XDREQ`  out  1  request to darkram.
- `XRD`  out  1  read strobe; equals XDREQ.
- `XWR`  out  1  constant 0.
- `XBE`  out  4  constant 4'hf.
- `XADDR`  out  ADDR_WIDTH  request address, word aligned.
- `XATAI`  out  32  constant 0.
- `XATAO`  in  32  read data from darkram, valid in the XDACK cycle.
- `XDACK`  in  1  acknowledge, one cycle per request.

## Operation
- States: IDLE, REQ, HOLD.
- Reset values: state IDLE; busy, done, error, rd_valid, XDREQ, XRD all 0; XADDR, rd_data, checksum all 0.
- IDLE, start=1, word_count≠0: latch `{base_addr[AW-1:2],2'b00}` into XADDR, remaining←word_count, checksum←0, error←0, busy←1, then go to REQ.
- IDLE, start=1, word_count=0: checksum←0, error←0, done pulse next cycle. No bus activity; busy stays 0.
- REQ: XDREQ=XRD=1 with XADDR stable.
  - On XDACK: rd_data←XATAO, rd_valid pulse, checksum←checksum+XATAO, remaining−1.
  - If remaining was 1: go to IDLE, busy←0, done pulse.
  - Otherwise: XADDR←XADDR+4, go to HOLD.
- HOLD: XDREQ=0. With advance=1, go to REQ next cycle; otherwise wait.
- Timeout: a cycle counter runs while in REQ and resets on each entry to REQ. If it reaches TIMEOUT with no XDACK: error←1, XDREQ←0, go to IDLE, busy←0, no done pulse. Checksum keeps the partial sum.
- XDACK seen outside REQ is ignored.
- start while busy is ignored.
- Address wrap: XADDR+4 wraps modulo 2^ADDR_WIDTH with no error.
- Reset mid-burst: all state returns to reset values immediately; the outstanding request is abandoned.

## Timing
- Accepted start in cycle 0 → busy=1 and XDREQ=1 in cycle 1.
- XDACK in cycle k → rd_valid=1 with the new rd_data and checksum in cycle k+1; XDREQ=0 in cycle k+1.
- With advance=1, the next XDREQ rises in cycle k+2. Throughput is one word per (ack latency + 2) cycles.
- Last word: done=1 and busy=0 in cycle k+1, together with the final rd_valid.
- Timeout: error=1 in the cycle after the TIMEOUT-th REQ cycle without ack.
- All outputs are registered. No combinational path runs from XDACK/XATAO to any output.

## Structure
- Shared package `xbus_pkg`:
  - State encoding constants: IDLE=2'd0, REQ=2'd1, HOLD=2'd2.
  - XBE_ALL=4'hf.
  - WORD_STRIDE=4.
- Single module; no sub-module required. The timeout counter is inline, sized by $clog2(TIMEOUT+1).

## Test plan
- Single word: base_addr=0x10, word_count=1, darkram model acks after 1 cycle with 0xDEADBEEF → one XDREQ at XADDR=0x10; rd_data=0xDEADBEEF; checksum=0xDEADBEEF; done pulse; busy=0.
- Burst: base 0x0, count 4, words 1,2,3,0xFFFFFFFF, advance=1 → XADDR sequence 0,4,8,C; four rd_valid pulses; checksum=0x00000005 (wraps); exactly one done.
- Pacing: count 2, advance held low for 10 cycles after the first ack → XDREQ low for those 10 cycles; second request at 0x4 issues the cycle after advance rises.
- Timeout: TIMEOUT=8, model never acks → error=1 after 8 REQ cycles; XDREQ=0; no done. Next start clears error.
- Edge cases: word_count=0 → done next cycle, no XDREQ. start while busy → ignored. base 0xFFFFFFFC, count 2 → second XADDR=0x0. base_addr=0x13 → XADDR=0x10.
- Reset mid-burst: reset asserted while XDREQ=1 → busy, XDREQ, checksum all 0 immediately; a later start runs normally.
